spm_product_collector: RTL

SPM_PRODUCT_COLLECTOR -- requirements
Module: spm_product_collector

---
 rtl/spm_product_collector.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spm_product_collector.sv
`timescale 1ns/1ps
// spm_product_collector
// Collects the LSB-first serial product stream of a bit-serial multiplier
// into a 2N-bit parallel word and hands it to a consumer with a
// valid/ready handshake. A new start strobe always wins. If it arrives
// while a finished product is still unaccepted, that product is dropped
// and a one-cycle overrun pulse is raised.

module spm_product_collector #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sbit,
    output logic [2*N-1:0] p,
    output logic           p_valid,
    input  logic           p_ready,
    output logic           busy,
    output logic           overrun
);

    localparam int PW = 2 * N;
    localparam int CW = $clog2(PW) + 1;

    // Count value held by the counter when the final (2N-th) sample is taken.
    localparam logic [CW-1:0] LAST_COUNT = CW'(PW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [PW-1:0]   r_shiftReg;
    logic [CW-1:0]   r_count;
    logic            r_overrun;

    logic            w_sample;
    logic            w_lastSample;
    logic            w_discard;

    // A sampling edge is any COLLECT edge without start. The edge that sees
    // start only clears, so the first product bit arrives one edge later.
    assign w_sample     = (r_state == COLLECT) && !start;
    assign w_lastSample = w_sample && (r_count == LAST_COUNT);

    // A restart in DONE with no simultaneous accept throws away a product.
    assign w_discard    = (r_state == DONE) && start && !p_ready;

    // State register; reset drops any partial or finished product at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start restarts from every state, the 2N-th sample
    // completes the product, and an accept in DONE returns to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = COLLECT;
                end
            end
            COLLECT: begin
                if (start) begin
                    w_nextState = COLLECT;
                end else if (w_lastSample) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_nextState = COLLECT;
                end else if (p_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Shift register and sample counter. Start clears both. Each sample
    // shifts right with the new bit entering at the top, so after 2N samples
    // the first bit sits at bit 0. Outside of sampling both hold, which keeps
    // p frozen through DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shiftReg <= '0;
            r_count    <= '0;
        end else if (start) begin
            r_shiftReg <= '0;
            r_count    <= '0;
        end else if (w_sample) begin
            r_shiftReg <= {sbit, r_shiftReg[PW-1:1]};
            r_count    <= r_count + 1'b1;
        end
    end

    // Overrun flag: high for exactly the cycle after a product is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_discard;
        end
    end

    // Output decode uses registered state only, so no input reaches an
    // output without passing through a flop.
    always_comb begin
        busy    = (r_state == COLLECT);
        p_valid = (r_state == DONE);
        p       = r_shiftReg;
        overrun = r_overrun;
    end

    // Collecting and presenting a result are mutually exclusive.
    property pBusyValidExclusive;
        @(posedge clk) disable iff (!rst) !(busy && p_valid);
    endproperty
    aBusyValidExclusive: assert property (pBusyValidExclusive);

    // An overrun pulse always coincides with the restarted collection.
    property pOverrunImpliesBusy;
        @(posedge clk) disable iff (!rst) overrun |-> busy;
    endproperty
    aOverrunImpliesBusy: assert property (pOverrunImpliesBusy);

    // A held product does not move while the consumer stalls.
    property pHeldProductStable;
        @(posedge clk) disable iff (!rst)
            (p_valid && !p_ready && !start) |=> (p_valid && $stable(p));
    endproperty
    aHeldProductStable: assert property (pHeldProductStable);

    // The counter never runs past a full product.
    property pCountBounded;
        @(posedge clk) disable iff (!rst) r_count <= CW'(PW);
    endproperty
    aCountBounded: assert property (pCountBounded);

endmodule
